// File: rtl/fsb_pkg.sv
// Shared types for the FSB cycle tracker/terminator.
// State encoding and the IACK function-code constant.
package fsb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACT,
    T_ACK,
    T_VPA,
    T_BERR
  } state_t;

  localparam logic [2:0] FC_IACK = 3'b111;

endpackage

// File: rtl/fsb_cycle_term_if.sv
// FSB strobes, counter timeouts and cycle-termination outputs.
// master = CPU/counter side, slave = terminator.
interface fsb_cycle_term_if #(
  parameter int CNT_W = 8
);
  logic             nAS;
  logic             nDS;
  logic [2:0]       FC;
  logic             ACK;
  logic             TimeoutA;
  logic             TimeoutB;
  logic             CACT;
  logic             nDTACK;
  logic             nVPA;
  logic             nBERR;
  logic [CNT_W-1:0] BerrCnt;
  logic             Busy;

  modport master (
    output nAS, nDS, FC, ACK,
    output TimeoutA, TimeoutB,
    input  CACT, nDTACK, nVPA, nBERR,
    input  BerrCnt, Busy
  );

  modport slave (
    input  nAS, nDS, FC, ACK,
    input  TimeoutA, TimeoutB,
    output CACT, nDTACK, nVPA, nBERR,
    output BerrCnt, Busy
  );
endinterface

// File: rtl/fsb_cycle_term_sat_counter.sv
// Width-parameterised saturating incrementer.
// Holds at all-ones; cleared only by reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/fsb_cycle_term.sv
// FSB cycle tracker: raises CACT for the timeout counter and
// terminates with DTACK, autovector VPA or BERR.
module fsb_cycle_term
  import fsb_pkg::*;
#(
  parameter bit VPA_EN = 1'b1,
  parameter int CNT_W  = 8
) (
  input logic            FCLK,
  input logic            RST,
  fsb_cycle_term_if.slave bus
);
  state_t           r_state;
  state_t           w_next;
  logic             r_cact;
  logic             r_ndtack;
  logic             r_nvpa;
  logic             r_nberr;
  logic             r_busy;
  logic             w_cact;
  logic             w_ndtack;
  logic             w_nvpa;
  logic             w_nberr;
  logic             w_busy;
  logic             w_berr_inc;
  logic             w_iack_vpa;
  logic [CNT_W-1:0] w_cnt;

  assign w_iack_vpa = VPA_EN && bus.TimeoutA &&
                      (bus.FC == FC_IACK) && !bus.nDS;

  always_ff @(posedge FCLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_cact   <= 1'b0;
      r_ndtack <= 1'b1;
      r_nvpa   <= 1'b1;
      r_nberr  <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cact   <= w_cact;
      r_ndtack <= w_ndtack;
      r_nvpa   <= w_nvpa;
      r_nberr  <= w_nberr;
      r_busy   <= w_busy;
    end
  end

  // Timeouts only matter in ACT; stale ones in IDLE are dropped.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (!bus.nAS) w_next = ACT;
      end
      ACT: begin
        if (bus.nAS)           w_next = IDLE;
        else if (bus.ACK)      w_next = T_ACK;
        else if (bus.TimeoutB) w_next = T_BERR;
        else if (w_iack_vpa)   w_next = T_VPA;
      end
      T_ACK, T_VPA, T_BERR: begin
        if (bus.nAS) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_cact     = (w_next != IDLE);
    w_busy     = (w_next != IDLE);
    w_ndtack   = (w_next != T_ACK);
    w_nvpa     = (w_next != T_VPA);
    w_nberr    = (w_next != T_BERR);
    w_berr_inc = (r_state == ACT) && (w_next == T_BERR);
  end

  sat_counter #(
    .W(CNT_W)
  ) u_berr_cnt (
    .i_clk(FCLK),
    .i_rst(RST),
    .i_inc(w_berr_inc),
    .o_q  (w_cnt)
  );

  assign bus.CACT    = r_cact;
  assign bus.nDTACK  = r_ndtack;
  assign bus.nVPA    = r_nvpa;
  assign bus.nBERR   = r_nberr;
  assign bus.Busy    = r_busy;
  assign bus.BerrCnt = w_cnt;
endmodule

// File: tb/tb_fsb_cycle_term.sv
// Bench for fsb_cycle_term: VPA_EN=1 and VPA_EN=0 instances
// driven in lockstep and compared against a cycle-rule model.
module tb_fsb_cycle_term;
  logic       FCLK;
  logic       RST;
  logic       nAS;
  logic       nDS;
  logic [2:0] FC;
  logic       ACK;
  logic       TimeoutA;
  logic       TimeoutB;

  int n_tests = 0;
  int n_fail  = 0;

  // model: ph 0=no cycle,1=open,2=terminated; tm 1=ack,2=vpa,3=berr
  int ph [2];
  int tm [2];
  int cnt[2];

  fsb_cycle_term_if #(.CNT_W(8)) b1 ();
  fsb_cycle_term_if #(.CNT_W(8)) b0 ();

  assign b1.nAS = nAS;
  assign b1.nDS = nDS;
  assign b1.FC = FC;
  assign b1.ACK = ACK;
  assign b1.TimeoutA = TimeoutA;
  assign b1.TimeoutB = TimeoutB;
  assign b0.nAS = nAS;
  assign b0.nDS = nDS;
  assign b0.FC = FC;
  assign b0.ACK = ACK;
  assign b0.TimeoutA = TimeoutA;
  assign b0.TimeoutB = TimeoutB;

  fsb_cycle_term #(.VPA_EN(1'b1), .CNT_W(8)) u_dut1 (
    .FCLK(FCLK), .RST(RST), .bus(b1)
  );
  fsb_cycle_term #(.VPA_EN(1'b0), .CNT_W(8)) u_dut0 (
    .FCLK(FCLK), .RST(RST), .bus(b0)
  );

  logic [12:0] obs1;
  logic [12:0] obs0;
  assign obs1 = {b1.CACT, b1.nDTACK, b1.nVPA, b1.nBERR,
                 b1.Busy, b1.BerrCnt};
  assign obs0 = {b0.CACT, b0.nDTACK, b0.nVPA, b0.nBERR,
                 b0.Busy, b0.BerrCnt};

  initial FCLK = 1'b0;
  always #5 FCLK = ~FCLK;

  function automatic logic [12:0] expv(int i);
    logic [7:0] c;
    c = 8'(cnt[i]);
    return {ph[i] != 0,
            !(ph[i] == 2 && tm[i] == 1),
            !(ph[i] == 2 && tm[i] == 2),
            !(ph[i] == 2 && tm[i] == 3),
            ph[i] != 0, c};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; tm[i] = 0; cnt[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (RST) begin
        ph[i] = 0; tm[i] = 0; cnt[i] = 0;
      end else if (ph[i] == 0) begin
        if (!nAS) ph[i] = 1;
      end else if (nAS) begin
        ph[i] = 0;
      end else if (ph[i] == 1) begin
        if (ACK) begin
          ph[i] = 2; tm[i] = 1;
        end else if (TimeoutB) begin
          ph[i] = 2; tm[i] = 3;
          cnt[i] = (cnt[i] < 255) ? cnt[i] + 1 : 255;
        end else if (TimeoutA && i == 1 && FC == 3'b111 && !nDS) begin
          ph[i] = 2; tm[i] = 2;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge FCLK);
    #1;
  endtask

  task automatic idle_inputs();
    nAS = 1'b1; nDS = 1'b1; FC = 3'b000;
    ACK = 1'b0; TimeoutA = 1'b0; TimeoutB = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b1;
    model_reset();
    tick();
    tick();
    n_tests++;
    if (obs1 !== 13'h0E00) begin
      n_fail++;
      $display("FAIL reset_dut1: got %h want %h", obs1, 13'h0E00);
    end
    n_tests++;
    if (obs0 !== 13'h0E00) begin
      n_fail++;
      $display("FAIL reset_dut0: got %h want %h", obs0, 13'h0E00);
    end
    RST = 1'b0;
    TimeoutA = 1'b1;
    TimeoutB = 1'b1;
    tick();
    n_tests++;
    if (obs1 !== 13'h0E00) begin
      n_fail++;
      $display("FAIL idle_timeouts: got %h want %h", obs1, 13'h0E00);
    end
    idle_inputs();
  endtask

  task automatic test_normal_read();
    idle_inputs();
    nAS = 1'b0; nDS = 1'b0; FC = 3'b101;
    for (int k = 0; k < 9; k++) begin
      ACK = (k == 5);
      tick();
      n_tests++;
      if (obs1 !== expv(1)) begin
        n_fail++;
        $display("FAIL read_k%0d: got %h want %h", k, obs1, expv(1));
      end
    end
    n_tests++;
    if (b1.nDTACK !== 1'b0 || b1.CACT !== 1'b1) begin
      n_fail++;
      $display("FAIL read_dtack: got %b%b want 01",
               b1.nDTACK, b1.CACT);
    end
    nAS = 1'b1;
    tick();
    n_tests++;
    if (obs1 !== 13'h0E00) begin
      n_fail++;
      $display("FAIL read_end: got %h want %h", obs1, 13'h0E00);
    end
  endtask

  task automatic test_unanswered();
    idle_inputs();
    nAS = 1'b0; nDS = 1'b0; FC = 3'b101;
    for (int k = 0; k <= 300; k++) begin
      TimeoutA = (k == 40);
      TimeoutB = (k >= 300);
      tick();
      n_tests++;
      if (obs1 !== expv(1) || obs0 !== expv(0)) begin
        n_fail++;
        $display("FAIL unans_k%0d: got %h/%h want %h/%h",
                 k, obs1, obs0, expv(1), expv(0));
      end
    end
    n_tests++;
    if (b1.nBERR !== 1'b0 || b1.nVPA !== 1'b1 || b1.BerrCnt !== 8'd1) begin
      n_fail++;
      $display("FAIL unans_berr: got %b%b cnt %0d want 01 cnt 1",
               b1.nBERR, b1.nVPA, b1.BerrCnt);
    end
    TimeoutA = 1'b0;
    tick();
    nAS = 1'b1;
    TimeoutB = 1'b0;
    tick();
    n_tests++;
    if (obs1 !== expv(1) || b1.nBERR !== 1'b1) begin
      n_fail++;
      $display("FAIL unans_release: got %h want %h", obs1, expv(1));
    end
  endtask

  task automatic test_iack();
    idle_inputs();
    nAS = 1'b0; nDS = 1'b0; FC = 3'b111;
    for (int k = 0; k <= 60; k++) begin
      TimeoutA = (k == 20);
      TimeoutB = (k == 60);
      tick();
      n_tests++;
      if (obs1 !== expv(1) || obs0 !== expv(0)) begin
        n_fail++;
        $display("FAIL iack_k%0d: got %h/%h want %h/%h",
                 k, obs1, obs0, expv(1), expv(0));
      end
      if (k == 20) begin
        n_tests++;
        if ({b1.nVPA, b1.nDTACK, b1.nBERR, b0.nVPA} !== 4'b0111) begin
          n_fail++;
          $display("FAIL iack_vpa: got %b want 0111",
                   {b1.nVPA, b1.nDTACK, b1.nBERR, b0.nVPA});
        end
      end
    end
    n_tests++;
    if ({b1.nVPA, b0.nBERR, b0.nVPA} !== 3'b001) begin
      n_fail++;
      $display("FAIL iack_novpa: got %b want 001",
               {b1.nVPA, b0.nBERR, b0.nVPA});
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_collision();
    int c1;
    idle_inputs();
    nAS = 1'b0; nDS = 1'b0; FC = 3'b010;
    tick();
    tick();
    c1 = cnt[1];
    ACK = 1'b1;
    TimeoutB = 1'b1;
    tick();
    n_tests++;
    if ({b1.nDTACK, b1.nBERR} !== 2'b01 || b1.BerrCnt !== 8'(c1)) begin
      n_fail++;
      $display("FAIL collision: got %b cnt %0d want 01 cnt %0d",
               {b1.nDTACK, b1.nBERR}, b1.BerrCnt, c1);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    nAS = 1'b0; nDS = 1'b0; FC = 3'b001;
    tick();
    tick();
    tick();
    nAS = 1'b1;
    tick();
    n_tests++;
    if (obs1 !== expv(1) || b1.CACT !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: got %h want %h", obs1, expv(1));
    end
    TimeoutA = 1'b1;
    TimeoutB = 1'b1;
    tick();
    n_tests++;
    if ({b1.CACT, b1.nDTACK, b1.nVPA, b1.nBERR} !== 4'b0111) begin
      n_fail++;
      $display("FAIL stale_timeout: got %b want 0111",
               {b1.CACT, b1.nDTACK, b1.nVPA, b1.nBERR});
    end
    TimeoutA = 1'b0;
    TimeoutB = 1'b0;
    nAS = 1'b0;
    tick();
    n_tests++;
    if (b1.CACT !== 1'b1 || obs1 !== expv(1)) begin
      n_fail++;
      $display("FAIL reenter: got %h want %h", obs1, expv(1));
    end
    nAS = 1'b1;
    tick();
    nAS = 1'b0;
    tick();
    n_tests++;
    if (b1.CACT !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_cact: got %b want 1", b1.CACT);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 7) == 0) nAS = ~nAS;
      nDS = ($urandom_range(0, 3) == 0);
      FC = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom);
      ACK = ($urandom_range(0, 15) == 0);
      TimeoutA = ($urandom_range(0, 9) == 0);
      TimeoutB = ($urandom_range(0, 29) == 0);
      tick();
      n_tests++;
      if (obs1 !== expv(1) || obs0 !== expv(0)) begin
        n_fail++;
        $display("FAIL random_k%0d: got %h/%h want %h/%h",
                 k, obs1, obs0, expv(1), expv(0));
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    nAS = 1'b0; nDS = 1'b0; FC = 3'b101;
    tick();
    TimeoutB = 1'b1;
    tick();
    n_tests++;
    if (b1.nBERR !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset_berr: got %b want 0", b1.nBERR);
    end
    #1 RST = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (obs1 !== 13'h0E00 || obs0 !== 13'h0E00) begin
      n_fail++;
      $display("FAIL async_reset: got %h/%h want %h",
               obs1, obs0, 13'h0E00);
    end
    @(posedge FCLK);
    #2;
    idle_inputs();
    RST = 1'b0;
    @(posedge FCLK);
    #1;
    n_tests++;
    if (obs1 !== 13'h0E00) begin
      n_fail++;
      $display("FAIL post_reset: got %h want %h", obs1, 13'h0E00);
    end
  endtask

  task automatic test_saturation();
    idle_inputs();
    nDS = 1'b0; FC = 3'b110;
    for (int n = 0; n < 260; n++) begin
      nAS = 1'b0;
      tick();
      TimeoutB = 1'b1;
      tick();
      nAS = 1'b1;
      TimeoutB = 1'b0;
      tick();
      n_tests++;
      if (obs1 !== expv(1) || obs0 !== expv(0)) begin
        n_fail++;
        $display("FAIL sat_n%0d: got %h/%h want %h/%h",
                 n, obs1, obs0, expv(1), expv(0));
      end
    end
    n_tests++;
    if (b1.BerrCnt !== 8'd255 || b0.BerrCnt !== 8'd255) begin
      n_fail++;
      $display("FAIL saturate: got %0d/%0d want 255",
               b1.BerrCnt, b0.BerrCnt);
    end
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_normal_read();
    test_unanswered();
    test_iack();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fsb_cycle_term.md
Name: fsb_cycle_term

Overview:
- FSB cycle tracker and terminator, directly upstream and downstream of the timeout counter. It watches the CPU strobes and produces CACT, which the counter consumes.
- It then consumes TimeoutA and TimeoutB from the counter and terminates the cycle in one of three ways:
  - DTACK on normal downstream acknowledge;
  - VPA (autovector) for unanswered interrupt-acknowledge cycles after TimeoutA;
  - BERR for any cycle still unanswered after TimeoutB.
- Sits in the CPLD between the 68000 FSB and the memory/IO/bridge logic. All logic is clocked on FCLK.

Parameters:
- VPA_EN, 1, when 1 an IACK cycle still pending at TimeoutA terminates with VPA; when 0 it waits for TimeoutB.
- CNT_W, 8, width of the saturating bus-error event counter.

Ports:
- FCLK  in  1  FSB clock
- RST  in  1  asynchronous active-high reset
- nAS  in  1  CPU address strobe, active low, synchronous to FCLK
- nDS  in  1  combined data strobe (nLDS & nUDS low-any), active low
- FC  in  3  CPU function code; 3'b111 marks an IACK cycle
- ACK  in  1  downstream cycle-complete pulse/level, active high
- TimeoutA  in  1  from counter, short timeout
- TimeoutB  in  1  from counter, long timeout
- CACT  out  1  cycle active, to counter
- nDTACK  out  1  active low
- nVPA  out  1  active low
- nBERR  out  1  active low
- BerrCnt  out  CNT_W  saturating count of BERR terminations
- Busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock FCLK. Reset is asynchronous and active-high on RST. Every state and output register is cleared asynchronously by RST.
- Reset values: state=IDLE, CACT=0, nDTACK=1, nVPA=1, nBERR=1, BerrCnt=0, Busy=0.
- Registers: all outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, ACT, T_ACK, T_VPA, T_BERR.
- IDLE:
  - nAS sampled low -> ACT, CACT<=1 on the same edge.
  - CACT therefore rises 1 cycle after nAS is first sampled low.
- ACT: evaluated in priority order each edge.
  1. nAS high (cycle aborted) -> IDLE, CACT<=0.
  2. ACK=1 -> T_ACK, nDTACK<=0.
  3. TimeoutB=1 -> T_BERR, nBERR<=0, BerrCnt<=BerrCnt+1, saturating at all-ones.
  4. TimeoutA=1 && VPA_EN && FC==3'b111 && nDS==0 -> T_VPA, nVPA<=0.
  5. Otherwise stay in ACT.
- Simultaneous ACK and TimeoutB: ACK wins and no BERR is counted.
- TimeoutA and TimeoutB together on an IACK cycle: BERR wins.
- Timeouts are ignored in IDLE. The counter clears them one cycle after CACT falls, so stale high timeouts in the first IDLE cycle must have no effect.
- T_ACK / T_VPA / T_BERR:
  - Hold the respective strobe low and CACT=1 until nAS is sampled high.
  - On that edge go to IDLE: strobe<=1, CACT<=0.
  - ACK and timeouts are ignored while in these states.
- Back-to-back cycles: nAS high for one sampled edge always returns to IDLE. A new nAS low on the following edge re-enters ACT, giving a minimum 1 IDLE cycle with CACT=0 so the counter clears.
- Exclusivity: at most one of nDTACK, nVPA, nBERR is low at any time.
- Reset mid-cycle: all strobes are released immediately (asynchronously). The next cycle begins only from a fresh nAS low observed after RST deasserts.
- BerrCnt: wraps never, holds at 2^CNT_W-1. It is cleared only by RST.

Decomposition:
- Shared package fsb_pkg:
  - state enum (IDLE, ACT, T_ACK, T_VPA, T_BERR);
  - constant FC_IACK=3'b111.
- One natural sub-module: sat_counter (width-parameterised saturating incrementer) for BerrCnt.
- The remainder is a single FSM process plus output registers.

Test Plan:
- Normal read: nAS low at cycle 0, ACK=1 at cycle 5 -> CACT=1 from cycle 1; nDTACK=0 from cycle 6 until nAS high sampled, then CACT=0; BerrCnt stays 0.
- Unanswered memory cycle: nAS held low, FC=3'b101, ACK never, TimeoutA at 40, TimeoutB at 300 -> no nVPA; nBERR=0 one cycle after TimeoutB; BerrCnt=1; nBERR released on nAS high.
- IACK autovector: FC=3'b111, nDS=0, TimeoutA pulses at cycle 20 -> nVPA=0 at cycle 21, nDTACK/nBERR stay 1. Repeat with VPA_EN=0 -> nVPA stays 1 and the cycle ends in nBERR at TimeoutB.
- Priority collision: ACK and TimeoutB both high on the same edge in ACT -> nDTACK=0, nBERR=1, BerrCnt unchanged.
- Abort and back-to-back: nAS high after 3 ACT cycles -> IDLE, CACT=0 for ≥1 cycle. Hold TimeoutA=1 in the first IDLE cycle -> no termination. A new nAS low then re-asserts CACT.
- Reset and saturation: assert RST while in T_BERR -> nBERR=1 and CACT=0 asynchronously, BerrCnt=0. Then force 260 BERR cycles with CNT_W=8 -> BerrCnt=255.
